// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1/8N2 UART byte transmitter.
// It controls an external flexcounter and uses the counter's strobe as the bit-period tick.
module uart_tx_ctrl #(
  parameter int unsigned COUNTSIZE  = 1024,
  parameter int unsigned COUNTWIDTH = $clog2(COUNTSIZE),
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  serial_out,
  output logic                  ctr_nRST,
  output logic                  ctr_enable,
  output logic [COUNTWIDTH-1:0] ctr_max,
  input  logic                  ctr_strobe,
  input  logic [COUNTWIDTH-1:0] ctr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [0:0]  stop_idx_q, stop_idx_d;
  logic        serial_q, serial_d;
  logic        ctr_on_q, ctr_on_d;

  // The counter value is only useful for debug probing.
  logic unused_ctr_count;
  assign unused_ctr_count = ^ctr_count;

  // State, shift register and registered line/counter controls.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      serial_q   <= 1'b1;
      ctr_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      serial_q   <= serial_d;
      ctr_on_q   <= ctr_on_d;
    end
  end

  // Next-state logic. The registered outputs are derived from the next state,
  // so they change in the same cycle as the state they belong to.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    serial_d   = 1'b1;
    ctr_on_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d    = tx_data;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (ctr_strobe) state_d = DATA;
      end
      DATA: begin
        if (ctr_strobe) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (ctr_strobe) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) state_d = IDLE;
          else stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
    ctr_on_d = (state_d != IDLE);
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;
  assign ctr_nRST   = ctr_on_q;
  assign ctr_enable = ctr_on_q;
  assign ctr_max    = COUNTWIDTH'(BAUD_DIV - 1);

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Byte-serial transmitter that acts as the controller of a flexcounter instance. It drives the counter's reset, enable and terminal count, and consumes its strobe as the bit-period tick. It accepts a byte through a valid/ready handshake and shifts it out as an 8N1 (or 8N2) UART frame, LSB first. It sits between the ByteType character source and the serial pin, directly upstream of the counter it configures.

## Interface
Parameters:
- COUNTSIZE, 1024, counter range; must match the attached flexcounter.
- COUNTWIDTH, $clog2(COUNTSIZE), width of the counter max/count buses.
- BAUD_DIV, 868, clocks per bit; legal range 2..COUNTSIZE.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- tx_valid  input  1  a byte is offered on tx_data.
- tx_data  input  8  byte to transmit.
- tx_ready  output  1  the block can accept a byte this cycle.
- busy  output  1  a frame is in progress.
- serial_out  output  1  UART line; idles high.
- ctr_nRST  output  1  counter reset, active low, registered.
- ctr_enable  output  1  counter enable, registered.
- ctr_max  output  COUNTWIDTH  counter terminal value; constant BAUD_DIV-1.
- ctr_strobe  input  1  one-cycle pulse from the counter when count == ctr_max. The counter wraps to 0 in the same cycle.
- ctr_count  input  COUNTWIDTH  current counter value; unused except for debug/assertions.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_ready=1, busy=0, serial_out=1, ctr_nRST=0, ctr_enable=0.
  - On tx_valid && tx_ready: latch tx_data into the shift register, clear bit_idx and stop_idx, and go to START.
- START: serial_out=0. On ctr_strobe, go to DATA.
- DATA:
  - serial_out = shift[0].
  - On ctr_strobe: shift right by 1, increment bit_idx.
  - When bit_idx==7 and ctr_strobe, go to STOP.
- STOP:
  - serial_out=1.
  - On ctr_strobe: if stop_idx==STOP_BITS-1, go to IDLE; else increment stop_idx.
- In every non-IDLE state: ctr_nRST=1, ctr_enable=1, busy=1, tx_ready=0.
- ctr_strobe is ignored in IDLE.
- tx_data and tx_valid are ignored while busy. The latched byte is immune to input changes mid-frame.
- serial_out, ctr_nRST and ctr_enable are registered outputs (no combinational path from the inputs).
- tx_ready and busy are decoded from the state register.
- Holding the counter in reset while IDLE guarantees each frame's first bit period starts at count 0.
- Reset (nRST low, at any time including mid-frame):
  - State goes to IDLE immediately and the shift register clears.
  - Outputs: serial_out=1, busy=0, tx_ready=1, ctr_nRST=0, ctr_enable=0.
  - ctr_max is constant BAUD_DIV-1 regardless of reset.
  - A truncated frame is abandoned, never resumed.

## Timing
- Handshake accepted in cycle T:
  - In cycle T+1: serial_out=0, ctr_nRST=1, ctr_enable=1, busy=1.
  - The counter starts from 0 at T+1 and first strobes at T+BAUD_DIV.
- Each bit (start, 8 data, stop) occupies exactly BAUD_DIV cycles on serial_out.
- Frame length is (9+STOP_BITS)*BAUD_DIV cycles, from T+1 through T+(9+STOP_BITS)*BAUD_DIV.
- The last stop-bit strobe occurs at T+(9+STOP_BITS)*BAUD_DIV; the state is IDLE and tx_ready=1 in the next cycle.
- Back-to-back operation with tx_valid held high:
  - The next byte is accepted in that IDLE cycle.
  - Inter-frame gap is one extra clock of line-high beyond the stop bit(s).
- Throughput: one byte per (9+STOP_BITS)*BAUD_DIV+1 cycles.
- A strobe arriving in the same cycle as nRST assertion is discarded.

## Test plan
- Reset values, BAUD_DIV=4, STOP_BITS=1: assert nRST=0 -> serial_out=1, tx_ready=1, busy=0, ctr_nRST=0, ctr_enable=0, ctr_max=3.
- Single byte 0xA5 accepted at cycle 10 -> serial_out = 0 on cycles 11-14, then bits 1,0,1,0,0,1,0,1 at 4 cycles each over cycles 15-46, then 1 on cycles 47-50. tx_ready=1 at cycle 51; busy high on cycles 11-50 only.
- Back-to-back 0x00 then 0xFF with tx_valid held high -> second start bit begins exactly 4*10+1 = 41 cycles after the first. Exactly one idle-high clock between frames; 2 handshakes total.
- STOP_BITS=2, byte 0x3C -> line high for 8 cycles after the last data bit; frame is 44 cycles; tx_data toggling mid-frame does not alter the waveform.
- nRST pulsed low during data bit 3 of 0x81 -> serial_out=1 and ctr_nRST=0 asynchronously, state IDLE. A byte 0x55 sent afterwards produces a clean full frame.
- Spurious ctr_strobe forced high in IDLE for 5 cycles -> no state change, serial_out stays 1, tx_ready stays 1.
